ula_seq: RTL and testbench
==========================

# ula_seq

Multicycle sequencer that sits in front of the ULA and drives it. It accepts one instruction word per handshake, reads two operands from the register file, and presents `sel`/`X`/`Y` to the ULA. It then captures the result and the `neg`/`zero` flags, writes the result back to the register file, and signals completion. Throughput is one instruction per 4 cycles.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width; must match the ULA.
- `REG_AW`, 5: register-file address width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `instr`  in  32  instruction word: [31:28] op, [27:23] rd, [22:18] rs1, [17:13] rs2, [12] i, [11:0] imm.
- `rf_ra1`, `rf_ra2`  out  REG_AW  read addresses; register-file data returns the next cycle.
- `rf_rd1`, `rf_rd2`  in  DATA_W  read data.
- `rf_we`  out  1  write enable.
- `rf_wa`  out  REG_AW  write address.
- `rf_wd`  out  DATA_W  write data.
- `ula_sel`  out  4  ULA operation select.
- `ula_x`, `ula_y`  out  DATA_W  ULA operands.
- `ula_res`  in  DATA_W  ULA result.
- `ula_neg`, `ula_zero`  in  1  ULA flags.
- `flag_neg`, `flag_zero`  out  1  registered flags of the last legal instruction.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse, asserted together with `done`, for an illegal op.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, latch `instr` and go to READ.
- READ:
  - `rf_ra1`=rs1, `rf_ra2`=rs2, both from the latched word.
  - Go to EXEC.
- EXEC:
  - `ula_sel`=op.
  - `ula_x`=`rf_rd1`.
  - `ula_y` = i ? sign-extended imm[11:0] : `rf_rd2`.
  - Shift ops (0100, 0101): `ula_y` is masked to bits [4:0]; upper bits are zero.
  - Latch `ula_res`, `ula_neg` and `ula_zero` into internal result registers at the end of the cycle.
  - Go to WB.
- WB:
  - `done`=1.
  - Legal op:
    - `rf_we`=1 when rd≠0; rd=0 suppresses the write.
    - `rf_wa`=rd, `rf_wd`=latched result.
    - `flag_neg`/`flag_zero` take the latched flags, including when rd=0.
  - Go to IDLE.
- Legal ops are 0000–1010: add, sub, and, or, sll, srl, xor, not, xnor, mul, div.
- Ops 1011–1111 are illegal:
  - EXEC drives `ula_sel`=0.
  - WB pulses `illegal` with `done`.
  - `rf_we`=0; flags are unchanged.
- Division by zero (op 1010 with `ula_y`=0):
  - The sequencer overrides the ULA: result = all-ones, neg=1, zero=0.
- Multiply keeps the low DATA_W bits only; division is unsigned.
- Outside EXEC: `ula_sel`, `ula_x` and `ula_y` are driven to 0.
- Outside READ: `rf_ra1`/`rf_ra2` are 0.
- `rf_wa`/`rf_wd` are 0 when `rf_we`=0.

## Timing
- Accept at cycle 0 (handshake cycle). READ is cycle 1, EXEC cycle 2, WB cycle 3 (`done`, `rf_we`). `instr_ready` is high again in cycle 4.
- `instr_valid` is ignored outside IDLE. The instruction is captured only at the handshake, so later changes to `instr` have no effect.
- `flag_neg`/`flag_zero` change on the edge that ends WB and are visible from cycle 4.
- Reset values:
  - State = IDLE; `instr_ready`=1 from the cycle after `rst` falls.
  - All other outputs are 0, including both flags.
- Reset mid-operation: state returns to IDLE on the next edge. No write and no `done` occur. Flags are cleared. The in-flight instruction is dropped.
- `rst` and `instr_valid` both high in IDLE: reset wins and nothing is accepted.

## Structure
- Shared package `ula_pkg`:
  - Opcode constants `OP_ADD`…`OP_DIV` (4-bit; values are the ULA `sel` codes).
  - FSM state enum.
  - Instruction field bit positions.
  - Immediate width (12).
- Sub-module `ula_dec`: combinational field extraction, legality check, immediate sign extension, and shift-amount masking.
- The ULA is external and connected through the `ula_*` ports; it is not instantiated inside `ula_seq`.

## Test plan
- ADD: r1=5, r2=7, instr op=0000 rd=3 rs1=1 rs2=2 i=0 → cycle 3: `rf_we`=1, `rf_wa`=3, `rf_wd`=12, `done`=1; flags 0/0 from cycle 4.
- SUB to rd=0: r1=r2=9 → `rf_we`=0, `done`=1, `flag_zero`=1, `flag_neg`=0.
- Immediate: r1=5, op=0000 i=1 imm=0xFFF → `ula_y`=0xFFFFFFFF, `rf_wd`=4.
- Shift mask: r1=1, r2=33, op=0100 → `ula_y`=1, `rf_wd`=2.
- Divide by zero: r1=10, r2=0, op=1010 → `rf_wd`=0xFFFFFFFF, `flag_neg`=1. Illegal op=1011 → `done`=`illegal`=1, `rf_we`=0, flags unchanged.
- Reset in EXEC: `rst` high in cycle 2 → no `done`/`rf_we` ever; flags 0; `instr_ready`=1 the cycle after `rst` falls. Back-to-back valid → second accept exactly 4 cycles after the first.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: opcodes, FSM states and
// instruction-word field positions.
package ula_pkg;

  // ULA operation select codes; the sequencer passes these straight to sel.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_XNOR = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  // Instruction word layout: [31:28] op, [27:23] rd, [22:18] rs1,
  // [17:13] rs2, [12] i, [11:0] imm.
  localparam int OP_W        = 4;
  localparam int OP_LSB      = 28;
  localparam int REG_FIELD_W = 5;
  localparam int RD_LSB      = 23;
  localparam int RS1_LSB     = 18;
  localparam int RS2_LSB     = 13;
  localparam int I_BIT       = 12;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 12;
  localparam int SHAMT_W     = 5;

  // Codes above OP_DIV have no ULA operation behind them.
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op <= OP_DIV;
  endfunction

endpackage

// File: rtl/ula_dec.sv
// Combinational decode of the latched instruction word: field extraction,
// legality, immediate sign extension and shift-amount masking of operand Y.
module ula_dec
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rd2,
  output logic [3:0]        op,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic              legal,
  output logic [DATA_W-1:0] y
);

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] y_raw;
  logic              shift_op;

  assign op    = instr[OP_LSB +: OP_W];
  assign rd    = REG_AW'(instr[RD_LSB  +: REG_FIELD_W]);
  assign rs1   = REG_AW'(instr[RS1_LSB +: REG_FIELD_W]);
  assign rs2   = REG_AW'(instr[RS2_LSB +: REG_FIELD_W]);
  assign legal = is_legal(op);

  assign imm     = instr[IMM_LSB +: IMM_W];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign y_raw   = instr[I_BIT] ? imm_ext : rd2;

  // Shifts only use the low five bits; clearing the rest keeps the ULA from
  // seeing out-of-range shift amounts.
  assign shift_op = (op == OP_SLL) || (op == OP_SRL);
  assign y        = shift_op ? DATA_W'(y_raw[SHAMT_W-1:0]) : y_raw;

endmodule

// File: rtl/ula_seq.sv
// Four-cycle sequencer in front of an external ULA: accept, read operands,
// execute, write back. One instruction per 4 cycles.
module ula_seq
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [3:0]        ula_sel,
  output logic [DATA_W-1:0] ula_x,
  output logic [DATA_W-1:0] ula_y,
  input  logic [DATA_W-1:0] ula_res,
  input  logic              ula_neg,
  input  logic              ula_zero,
  output logic              flag_neg,
  output logic              flag_zero,
  output logic              done,
  output logic              illegal
);

  state_t            state, next_state;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  logic              neg_q, zero_q;

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              legal;
  logic [DATA_W-1:0] y;
  logic              accept, div0, wb_write;

  ula_dec #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_dec (
    .instr (instr_q),
    .rd2   (rf_rd2),
    .op    (op),
    .rd    (rd),
    .rs1   (rs1),
    .rs2   (rs2),
    .legal (legal),
    .y     (y)
  );

  assign accept   = instr_valid && instr_ready;
  assign div0     = (op == OP_DIV) && (y == '0);
  assign wb_write = legal && (rd != '0);

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Instruction latch, EXEC result capture and architectural flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      flag_neg  <= 1'b0;
      flag_zero <= 1'b0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == S_EXEC) begin
        // Divide by zero: force all-ones, negative, non-zero.
        res_q  <= div0 ? '1 : ula_res;
        neg_q  <= div0 | ula_neg;
        zero_q <= !div0 && ula_zero;
      end
      if ((state == S_WB) && legal) begin
        flag_neg  <= neg_q;
        flag_zero <= zero_q;
      end
    end
  end

  // Next-state logic and per-state output decode.
  always_comb begin
    // NOTE: every output is defaulted first so no path through the case
    // leaves a variable unassigned and infers a latch.
    next_state  = state;
    instr_ready = 1'b0;
    rf_ra1      = '0;
    rf_ra2      = '0;
    ula_sel     = '0;
    ula_x       = '0;
    ula_y       = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = !rst;
        if (instr_valid && !rst) next_state = S_READ;
      end
      S_READ: begin
        rf_ra1     = rs1;
        rf_ra2     = rs2;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        ula_sel    = legal ? op : 4'h0;
        ula_x      = rf_rd1;
        ula_y      = y;
        next_state = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        illegal = !legal;
        rf_we   = wb_write;
        if (wb_write) begin
          rf_wa = rd;
          rf_wd = res_q;
        end
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq with a behavioural ULA, a register file model
// and a scoreboard of expected write-back transactions.
`timescale 1ns/1ps
module tb_ula_seq;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ill;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [31:0]       instr = '0;
  logic [REG_AW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
  logic              rf_we;
  logic [3:0]        ula_sel;
  logic [DATA_W-1:0] ula_x, ula_y, ula_res;
  logic              ula_neg, ula_zero;
  logic              flag_neg, flag_zero, done, illegal;

  logic [31:0] rf [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_a = '0;
  logic [31:0] pre_d = '0;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic fn = 1'b0;
  logic fz = 1'b0;

  always #5 clk = ~clk;

  ula_seq #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra1      (rf_ra1),
    .rf_ra2      (rf_ra2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .ula_sel     (ula_sel),
    .ula_x       (ula_x),
    .ula_y       (ula_y),
    .ula_res     (ula_res),
    .ula_neg     (ula_neg),
    .ula_zero    (ula_zero),
    .flag_neg    (flag_neg),
    .flag_zero   (flag_zero),
    .done        (done),
    .illegal     (illegal)
  );

  // Reference ULA; a zero divisor yields 0 so the sequencer override shows.
  function automatic logic [31:0] ula_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a << b[4:0];
      4'h5: return a >> b[4:0];
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'h8: return ~(a ^ b);
      4'h9: return a * b;
      4'hA: return (b == 0) ? 32'h0 : a / b;
      default: return 32'h0;
    endcase
  endfunction

  // External ULA driven by the sequencer.
  always_comb begin
    ula_res  = ula_f(ula_sel, ula_x, ula_y);
    ula_neg  = ula_res[31];
    ula_zero = (ula_res == 32'h0);
  end

  // Register file: one-cycle read latency, write-back or bench preload.
  always @(posedge clk) begin
    rf_rd1 <= rf[rf_ra1];
    rf_rd2 <= rf[rf_ra2];
    if (rf_we)       rf[rf_wa] <= rf_wd;
    else if (pre_we) rf[pre_a] <= pre_d;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic i, input logic [11:0] imm);
    logic [31:0] x, y, res;
    logic        legal, div0;
    exp_t        e;
    int          n;
    legal = (op <= 4'hA);
    x     = rf[rs1];
    y     = i ? {{20{imm[11]}}, imm} : rf[rs2];
    if (op == 4'h4 || op == 4'h5) y = {27'd0, y[4:0]};
    div0  = legal && (op == 4'hA) && (y == 32'h0);
    res   = div0 ? 32'hFFFF_FFFF : ula_f(op, x, y);
    e.we  = legal && (rd != 5'd0);
    e.wa  = e.we ? rd : 5'd0;
    e.wd  = e.we ? res : 32'h0;
    e.ill = !legal;
    sb.push_back(e);

    @(negedge clk);  // cycle 0: handshake
    check("idle_ready", instr_ready, 1);
    instr       = {op, rd, rs1, rs2, i, imm};
    instr_valid = 1'b1;
    @(negedge clk);  // cycle 1: READ
    instr_valid = 1'b0;
    instr       = $urandom;
    check("read_ra1", rf_ra1, rs1);
    check("read_ra2", rf_ra2, rs2);
    check("read_ready", instr_ready, 0);
    check("read_sel", ula_sel, 0);
    @(negedge clk);  // cycle 2: EXEC
    check("exec_sel", ula_sel, legal ? op : 4'h0);
    check("exec_ra1", rf_ra1, 0);
    if (legal) begin
      check("exec_x", ula_x, x);
      check("exec_y", ula_y, y);
    end
    @(negedge clk);  // cycle 3: WB expected
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 0);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check("wb_we", rf_we, e.we);
      check("wb_wa", rf_wa, e.wa);
      check("wb_wd", rf_wd, e.wd);
      check("wb_illegal", illegal, e.ill);
      check("wb_sel", ula_sel, 0);
    end
    if (legal) begin
      fn = div0 | res[31];
      fz = !div0 && (res == 32'h0);
    end
    @(negedge clk);  // cycle 4
    check("c4_flag_neg", flag_neg, fn);
    check("c4_flag_zero", flag_zero, fz);
    check("c4_ready", instr_ready, 1);
    check("c4_done", done, 0);
  endtask

  initial begin
    exp_t e;
    int   bad, acc_n, acc0, acc1, done_n;

    // Reset with register file cleared.
    rst = 1'b1;
    for (int r = 0; r < 32; r++) set_reg(r[4:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_we", rf_we, 0);
    check("rst_illegal", illegal, 0);
    check("rst_flag_neg", flag_neg, 0);
    check("rst_flag_zero", flag_zero, 0);
    check("rst_sel", ula_sel, 0);
    check("rst_ra1", rf_ra1, 0);

    // ADD r3 = 5 + 7.
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    issue(4'h0, 5'd3, 5'd1, 5'd2, 1'b0, 12'h0);

    // SUB to r0: write suppressed, zero flag still set.
    set_reg(5'd1, 32'd9);
    set_reg(5'd2, 32'd9);
    issue(4'h1, 5'd0, 5'd1, 5'd2, 1'b0, 12'h0);

    // Immediate -1 added to 5.
    set_reg(5'd1, 32'd5);
    issue(4'h0, 5'd6, 5'd1, 5'd0, 1'b1, 12'hFFF);

    // Shift amount 33 masks to 1.
    set_reg(5'd1, 32'd1);
    set_reg(5'd2, 32'd33);
    issue(4'h4, 5'd7, 5'd1, 5'd2, 1'b0, 12'h0);

    // Negative SUB, MUL low bits, ordinary unsigned DIV.
    set_reg(5'd1, 32'd3);
    set_reg(5'd2, 32'd8);
    issue(4'h1, 5'd8, 5'd1, 5'd2, 1'b0, 12'h0);
    set_reg(5'd1, 32'h0001_0000);
    set_reg(5'd2, 32'h0001_0003);
    issue(4'h9, 5'd9, 5'd1, 5'd2, 1'b0, 12'h0);
    set_reg(5'd1, 32'hFFFF_FF9C);
    set_reg(5'd2, 32'd7);
    issue(4'hA, 5'd10, 5'd1, 5'd2, 1'b0, 12'h0);

    // Divide by zero, then an illegal op leaving flags alone.
    set_reg(5'd1, 32'd10);
    set_reg(5'd2, 32'd0);
    issue(4'hA, 5'd11, 5'd1, 5'd2, 1'b0, 12'h0);
    issue(4'hB, 5'd12, 5'd1, 5'd2, 1'b0, 12'h0);
    issue(4'hF, 5'd13, 5'd1, 5'd2, 1'b1, 12'h123);

    // Reset while in EXEC; valid also high during reset in IDLE.
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    @(negedge clk);
    instr       = {4'h0, 5'd14, 5'd1, 5'd2, 1'b0, 12'h0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstx_we_during", rf_we, 0);
    check("rstx_done_during", done, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    instr_valid = 1'b0;
    fn = 1'b0;
    fz = 1'b0;
    check("rstx_flag_neg", flag_neg, 0);
    check("rstx_flag_zero", flag_zero, 0);
    @(negedge clk);
    check("rstx_ready", instr_ready, 1);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || rf_we || !instr_ready) bad++;
    end
    check("rstx_quiet", bad, 0);

    // Back-to-back: valid held high, accepts exactly 4 cycles apart.
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    for (int k = 0; k < 2; k++) begin
      e.we = 1'b1; e.wa = 5'd4; e.wd = 32'd12; e.ill = 1'b0;
      sb.push_back(e);
    end
    instr       = {4'h0, 5'd4, 5'd1, 5'd2, 1'b0, 12'h0};
    instr_valid = 1'b1;
    acc_n = 0; acc0 = 0; acc1 = 0; done_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (instr_ready && instr_valid) begin
        if (acc_n == 0) acc0 = c;
        else if (acc_n == 1) acc1 = c;
        acc_n++;
      end
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        check("b2b_wa", rf_wa, e.wa);
        check("b2b_wd", rf_wd, e.wd);
        done_n++;
      end
    end
    instr_valid = 1'b0;
    check("b2b_accepts", acc_n, 2);
    check("b2b_spacing", acc1 - acc0, 4);
    check("b2b_done_count", done_n, 2);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
